// File: rtl/time_display_driver_pkg.sv
// rtl/time_display_driver_pkg.sv - segment codes, FSM states and BCD helpers for the time display
// Purpose: shared constants and pure functions used by the display driver and its BCD engine.
// Ports: none (package).
package display_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [4:0] HOURS_MAX  = 5'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    typedef enum logic [2:0] {IDLE, CAPTURE, CONV_A, CONV_B, COMMIT} state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration on {tens, ones, binary}
    function automatic logic [13:0] dabble_step(input logic [13:0] sr);
        logic [13:0] t;
        t = sr;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/time_display_driver_if.sv
// rtl/time_display_driver_if.sv - time input and display output bundle
// Purpose: groups timekeeper inputs and display drive outputs.
// Ports: hours/minutes/seconds/show_seconds (to driver), seg/an/dp/busy (from driver).
interface time_display_driver_if;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       show_seconds;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    modport master (output hours, minutes, seconds, show_seconds,
                    input  seg, an, dp, busy);
    modport slave  (input  hours, minutes, seconds, show_seconds,
                    output seg, an, dp, busy);
endinterface

// File: rtl/time_display_driver_bin2bcd_seq.sv
// rtl/time_display_driver_bin2bcd_seq.sv - 6-bit sequential double-dabble converter
// Purpose: converts a 6-bit binary value to two BCD nibbles over six iterations.
// Ports: clk, reset, start_i (load+first iteration), bin_i, bcd_o {tens,ones}, done_o (1-cycle pulse).
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [5:0] bin_i,
    output logic [7:0] bcd_o,
    output logic       done_o
);

    logic [13:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        active_q, active_d;

    // The first iteration happens on the load edge so that six iterations
    // finish exactly when done_o is seen by the controller.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            sr_d     = dabble_step({8'h00, bin_i});
            cnt_d    = 3'd5;
            active_d = 1'b1;
        end else if (cnt_q != 3'd0) begin
            sr_d  = dabble_step(sr_q);
            cnt_d = cnt_q - 3'd1;
        end else begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign bcd_o  = sr_q[13:6];
    assign done_o = active_q && (cnt_q == 3'd0);

endmodule

// File: rtl/time_display_driver.sv
// rtl/time_display_driver.sv - 4-digit multiplexed 7-segment time display driver
// Purpose: snapshots the time once per scan frame, converts it to BCD and commits all digits at once.
// Ports: clk, reset (async, active-high), dif (slave: time in, seg/an/dp/busy out).
module time_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
)
(
    input  logic                  clk,
    input  logic                  reset,
    time_display_driver_if.slave  dif
);

    localparam int CW = $clog2(SCAN_DIV);

    // Scan divider and request generator
    logic [CW-1:0] scan_cnt_q;
    logic [1:0]    digit_sel_q;
    logic          first_q;
    logic          scan_tc, conv_req;

    assign scan_tc  = (scan_cnt_q == CW'(SCAN_DIV - 1));
    assign conv_req = first_q | (scan_tc & (digit_sel_q == 2'd3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_sel_q <= 2'd0;
            first_q     <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (scan_tc) begin
                scan_cnt_q  <= '0;
                digit_sel_q <= digit_sel_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + CW'(1);
            end
        end
    end

    // Field selection and range check on the live inputs (used in CAPTURE)
    logic [5:0] field_a, field_b;
    logic       bad_a, bad_b;

    always_comb begin
        if (dif.show_seconds) begin
            field_a = dif.minutes;
            field_b = dif.seconds;
            bad_a   = dif.minutes > MINSEC_MAX;
            bad_b   = dif.seconds > MINSEC_MAX;
        end else begin
            field_a = {1'b0, dif.hours};
            field_b = dif.minutes;
            bad_a   = dif.hours > HOURS_MAX;
            bad_b   = dif.minutes > MINSEC_MAX;
        end
    end

    // Control FSM
    state_t     state_q, state_d;
    logic       eng_start, eng_done;
    logic [5:0] eng_bin, cap_b_q;
    logic [7:0] eng_bcd;
    logic       capture_en, save_a, commit_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (conv_req) state_d = CAPTURE;
            CAPTURE: state_d = CONV_A;
            CONV_A:  if (eng_done) state_d = CONV_B;
            CONV_B:  if (eng_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Field A is started straight from the live inputs while they are captured;
    // field B is started from the captured copy as soon as A completes.
    always_comb begin
        capture_en = (state_q == CAPTURE);
        save_a     = (state_q == CONV_A) && eng_done;
        commit_en  = (state_q == COMMIT);
        eng_start  = capture_en || save_a;
        eng_bin    = capture_en ? field_a : cap_b_q;
    end

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (eng_start),
        .bin_i   (eng_bin),
        .bcd_o   (eng_bcd),
        .done_o  (eng_done)
    );

    // Captured values and display registers (disp_q[0] is the leftmost digit)
    logic       bad_a_q, bad_b_q, cap_colon_q, colon_q;
    logic [7:0] bcd_a_q;
    logic [6:0] disp_q [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_b_q     <= '0;
            bad_a_q     <= 1'b0;
            bad_b_q     <= 1'b0;
            cap_colon_q <= 1'b0;
            bcd_a_q     <= '0;
            colon_q     <= 1'b0;
            for (int i = 0; i < 4; i++) disp_q[i] <= SEG_BLANK;
        end else begin
            if (capture_en) begin
                cap_b_q     <= field_b;
                bad_a_q     <= bad_a;
                bad_b_q     <= bad_b;
                // Colon lit: steady in MM:SS, blinks on even seconds in HH:MM
                cap_colon_q <= dif.show_seconds | ~dif.seconds[0];
            end
            if (save_a) bcd_a_q <= eng_bcd;
            if (commit_en) begin
                disp_q[0] <= bad_a_q ? SEG_DASH : bcd_to_seg(bcd_a_q[7:4]);
                disp_q[1] <= bad_a_q ? SEG_DASH : bcd_to_seg(bcd_a_q[3:0]);
                disp_q[2] <= bad_b_q ? SEG_DASH : bcd_to_seg(eng_bcd[7:4]);
                disp_q[3] <= bad_b_q ? SEG_DASH : bcd_to_seg(eng_bcd[3:0]);
                colon_q   <= cap_colon_q;
            end
        end
    end

    // Output registers
    logic [6:0] seg_q;
    logic [3:0] an_q;
    logic       dp_q, busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q  <= SEG_BLANK;
            an_q   <= 4'hF;
            dp_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            seg_q  <= disp_q[digit_sel_q];
            an_q   <= ~(4'b1000 >> digit_sel_q);
            dp_q   <= ~((digit_sel_q == 2'd2) && colon_q);
            busy_q <= (state_d != IDLE);
        end
    end

    assign dif.seg  = seg_q;
    assign dif.an   = an_q;
    assign dif.dp   = dp_q;
    assign dif.busy = busy_q;

endmodule
